// File: rtl/nor_array_sequencer.sv
// Drives one shared external WIDTH-bit NOR array through a short per-opcode pass
// sequence, composing NOR/NOT/OR/AND/NAND/XNOR/XOR/BUF from NOR passes alone.
module nor_array_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] nor_a,
    output logic [WIDTH-1:0] nor_b,
    input  logic [WIDTH-1:0] nor_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_A,
        SRC_B,
        SRC_T1,
        SRC_T2,
        SRC_T3
    } src_e;

    typedef enum logic [1:0] {
        DST_T1,
        DST_T2,
        DST_T3,
        DST_R
    } dst_e;

    typedef struct packed {
        src_e x;
        src_e y;
        dst_e dst;
    } pass_t;

    state_e           state_q;
    logic [2:0]       step_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] t1_q;
    logic [WIDTH-1:0] t2_q;
    logic [WIDTH-1:0] t3_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;

    pass_t            pass_cur;

    function automatic pass_t mk(input src_e x, input src_e y, input dst_e d);
        pass_t p;
        p.x   = x;
        p.y   = y;
        p.dst = d;
        return p;
    endfunction

    // A pass whose dst is DST_R is the final pass of its opcode.
    function automatic pass_t pass_decode(input logic [2:0] op_v, input logic [2:0] step_v);
        pass_t p;
        p = mk(SRC_ZERO, SRC_ZERO, DST_R);
        case (op_v)
            3'd0: p = mk(SRC_A, SRC_B, DST_R);
            3'd1: p = mk(SRC_A, SRC_A, DST_R);
            3'd2: begin
                case (step_v)
                    3'd0:    p = mk(SRC_A,  SRC_B,  DST_T1);
                    default: p = mk(SRC_T1, SRC_T1, DST_R);
                endcase
            end
            3'd3: begin
                case (step_v)
                    3'd0:    p = mk(SRC_A,  SRC_A,  DST_T1);
                    3'd1:    p = mk(SRC_B,  SRC_B,  DST_T2);
                    default: p = mk(SRC_T1, SRC_T2, DST_R);
                endcase
            end
            3'd4: begin
                case (step_v)
                    3'd0:    p = mk(SRC_A,  SRC_A,  DST_T1);
                    3'd1:    p = mk(SRC_B,  SRC_B,  DST_T2);
                    3'd2:    p = mk(SRC_T1, SRC_T2, DST_T3);
                    default: p = mk(SRC_T3, SRC_T3, DST_R);
                endcase
            end
            3'd5: begin
                case (step_v)
                    3'd0:    p = mk(SRC_A,  SRC_B,  DST_T1);
                    3'd1:    p = mk(SRC_A,  SRC_T1, DST_T2);
                    3'd2:    p = mk(SRC_B,  SRC_T1, DST_T3);
                    default: p = mk(SRC_T2, SRC_T3, DST_R);
                endcase
            end
            3'd6: begin
                case (step_v)
                    3'd0:    p = mk(SRC_A,  SRC_B,  DST_T1);
                    3'd1:    p = mk(SRC_A,  SRC_T1, DST_T2);
                    3'd2:    p = mk(SRC_B,  SRC_T1, DST_T3);
                    3'd3:    p = mk(SRC_T2, SRC_T3, DST_T1);
                    default: p = mk(SRC_T1, SRC_T1, DST_R);
                endcase
            end
            default: begin
                case (step_v)
                    3'd0:    p = mk(SRC_A,  SRC_A,  DST_T1);
                    default: p = mk(SRC_T1, SRC_T1, DST_R);
                endcase
            end
        endcase
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] pick(
        input src_e             s,
        input logic [WIDTH-1:0] va,
        input logic [WIDTH-1:0] vb,
        input logic [WIDTH-1:0] v1,
        input logic [WIDTH-1:0] v2,
        input logic [WIDTH-1:0] v3
    );
        logic [WIDTH-1:0] v;
        v = '0;
        case (s)
            SRC_A:   v = va;
            SRC_B:   v = vb;
            SRC_T1:  v = v1;
            SRC_T2:  v = v2;
            SRC_T3:  v = v3;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign pass_cur = pass_decode(op_q, step_q);

    // Array inputs are only non-zero while a pass is actually being evaluated.
    always_comb begin
        nor_a = '0;
        nor_b = '0;
        if (state_q == ST_RUN) begin
            nor_a = pick(pass_cur.x, a_q, b_q, t1_q, t2_q, t3_q);
            nor_b = pick(pass_cur.y, a_q, b_q, t1_q, t2_q, t3_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            t3_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        step_q  <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    case (pass_cur.dst)
                        DST_T1: t1_q <= nor_out;
                        DST_T2: t2_q <= nor_out;
                        DST_T3: t3_q <= nor_out;
                        default: begin
                            result_q <= nor_out;
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    endcase
                    if (pass_cur.dst != DST_R) begin
                        step_q <= step_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
